// File: rtl/tdsp_bus_pkg.sv
// Shared types and defaults for the tdsp bus arbiter and its request picker.
package tdsp_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  // Watchdog must count 0..TIMEOUT-1 and still be wide enough for TIMEOUT itself.
  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/tdsp_rr_pick.sv
// Combinational priority picker: first set request scanning upward from ptr_i
// with wrap. Returns the one-hot grant and its binary index.
module tdsp_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o
);

  localparam int SW = PTR_W + 1;
  localparam logic [PTR_W:0] SUM_N = SW'(N_REQ);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] j;
  logic             found;

  // ptr + k never reaches 2*N_REQ, so a single conditional subtract wraps it.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr_i} + SW'(k);
      if (sum >= SUM_N) sum = sum - SUM_N;
      j = sum[PTR_W-1:0];
      if (!found && req_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/tdsp_bus_arbiter.sv
// N-requester arbiter onto one shared memory/port bus: latches the winner's
// request, holds it through BUSY, returns a one-cycle ack (or watchdog err).
module tdsp_bus_arbiter
  import tdsp_bus_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [N_REQ-1:0]          req_go_i,
  input  logic [N_REQ-1:0]          req_read_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          req_ack_o,
  output logic [N_REQ-1:0]          req_err_o,
  output logic [DATA_W-1:0]         req_rdata_o,
  output logic                      bus_go_o,
  output logic                      bus_read_o,
  output logic [ADDR_W-1:0]         bus_addr_o,
  output logic [DATA_W-1:0]         bus_wdata_o,
  input  logic                      bus_done_i,
  input  logic [DATA_W-1:0]         bus_rdata_i
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WD_W  = wd_width(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  state_e             state_q, state_d;
  logic               bus_read_q, bus_read_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   win_q, win_d;
  logic [N_REQ-1:0]   win_oh_q, win_oh_d;
  logic               ok_q, ok_d;

  logic [PTR_W-1:0]   pick_ptr;
  logic [PTR_W-1:0]   pick_idx;
  logic [N_REQ-1:0]   pick_gnt;

  assign pick_ptr = (RR_MODE != 0) ? rr_ptr_q : '0;

  tdsp_rr_pick #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_pick (
    .req_i (req_go_i),
    .ptr_i (pick_ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      bus_read_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      wd_q        <= '0;
      rr_ptr_q    <= '0;
      win_q       <= '0;
      win_oh_q    <= '0;
      ok_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_read_q  <= bus_read_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      wd_q        <= wd_d;
      rr_ptr_q    <= rr_ptr_d;
      win_q       <= win_d;
      win_oh_q    <= win_oh_d;
      ok_q        <= ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_read_d  = bus_read_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    wd_d        = wd_q;
    rr_ptr_d    = rr_ptr_q;
    win_d       = win_q;
    win_oh_d    = win_oh_q;
    ok_d        = ok_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_go_i) begin
          state_d     = ST_BUSY;
          win_d       = pick_idx;
          win_oh_d    = pick_gnt;
          bus_read_d  = req_read_i[pick_idx];
          bus_addr_d  = req_addr_i[pick_idx*ADDR_W +: ADDR_W];
          bus_wdata_d = req_wdata_i[pick_idx*DATA_W +: DATA_W];
          wd_d        = '0;
        end
      end
      ST_BUSY: begin
        // Completion takes precedence over a watchdog expiring in the same cycle.
        if (bus_done_i) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
          if (bus_read_q) rdata_d = bus_rdata_i;
        end else if (wd_q == WD_LAST) begin
          state_d = ST_DONE;
          ok_d    = 1'b0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_go_o    = (state_q == ST_BUSY);
    bus_read_o  = bus_read_q;
    bus_addr_o  = bus_addr_q;
    bus_wdata_o = bus_wdata_q;
    req_rdata_o = rdata_q;
    req_ack_o   = '0;
    req_err_o   = '0;
    if (state_q == ST_DONE) begin
      if (ok_q) req_ack_o = win_oh_q;
      else      req_err_o = win_oh_q;
    end
  end

endmodule

// File: tb/tb_tdsp_bus_arbiter.sv
// Bench for tdsp_bus_arbiter: directed cases plus randomized traffic against a
// transaction-level model, and a fixed-priority instance under saturation.
module tb_tdsp_bus_arbiter;

  localparam int TO = 5;

  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  // Round-robin instance under test
  logic [3:0]       go_a, rd_a;
  logic [3:0][15:0] addr_a, wd_a;
  logic             done_a;
  logic [15:0]      brd_a;
  logic [3:0]       ack_a, err_a;
  logic [15:0]      rdata_a, baddr_a, bwdata_a;
  logic             bgo_a, bread_a;

  // Fixed-priority instance, saturated
  logic [3:0]       go_b, rd_b;
  logic [3:0][15:0] addr_b, wd_b;
  logic             done_b;
  logic [15:0]      brd_b;
  logic [3:0]       ack_b, err_b;
  logic [15:0]      rdata_b, baddr_b, bwdata_b;
  logic             bgo_b, bread_b;

  tdsp_bus_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16), .RR_MODE(1), .TIMEOUT(TO)) dut_a (
    .clk_i(clk), .reset_i(rst), .req_go_i(go_a), .req_read_i(rd_a),
    .req_addr_i(addr_a), .req_wdata_i(wd_a), .req_ack_o(ack_a), .req_err_o(err_a),
    .req_rdata_o(rdata_a), .bus_go_o(bgo_a), .bus_read_o(bread_a), .bus_addr_o(baddr_a),
    .bus_wdata_o(bwdata_a), .bus_done_i(done_a), .bus_rdata_i(brd_a)
  );

  tdsp_bus_arbiter #(.N_REQ(4), .ADDR_W(16), .DATA_W(16), .RR_MODE(0), .TIMEOUT(TO)) dut_b (
    .clk_i(clk), .reset_i(rst), .req_go_i(go_b), .req_read_i(rd_b),
    .req_addr_i(addr_b), .req_wdata_i(wd_b), .req_ack_o(ack_b), .req_err_o(err_b),
    .req_rdata_o(rdata_b), .bus_go_o(bgo_b), .bus_read_o(bread_b), .bus_addr_o(baddr_b),
    .bus_wdata_o(bwdata_b), .bus_done_i(done_b), .bus_rdata_i(brd_b)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model of instance A
  int          m_valid = 0;
  int          m_ph;      // 0 waiting for request, 1 on bus, 2 reporting
  int          m_age, m_win, m_ptr, m_ok;
  logic        e_go, e_read;
  logic [15:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_ack, e_err;

  function automatic int pick(input logic [3:0] g, input int p);
    for (int k = 0; k < 4; k++) if (g[(p + k) % 4]) return (p + k) % 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1; m_ph = 0; m_age = 0; m_win = 0; m_ptr = 0; m_ok = 0;
      e_read = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      case (m_ph)
        0: if (go_a != 4'b0) begin
             m_win = pick(go_a, m_ptr);
             e_read = rd_a[m_win]; e_addr = addr_a[m_win]; e_wdata = wd_a[m_win];
             m_age = 0; m_ph = 1;
           end
        1: begin
             m_age++;
             if (done_a) begin
               m_ok = 1; m_ph = 2;
               if (e_read) e_rdata = brd_a;
             end else if (m_age == TO) begin
               m_ok = 0; m_ph = 2;
             end
           end
        default: begin m_ph = 0; m_ptr = (m_win + 1) % 4; end
      endcase
    end
    e_go  = (m_ph == 1);
    e_ack = (m_ph == 2 && m_ok == 1) ? 4'(1 << m_win) : 4'b0;
    e_err = (m_ph == 2 && m_ok == 0) ? 4'(1 << m_win) : 4'b0;
  end

  always @(negedge clk) begin
    if (m_valid != 0) begin
      chk("m_bus_go",    32'(bgo_a),    32'(e_go));
      chk("m_bus_read",  32'(bread_a),  32'(e_read));
      chk("m_bus_addr",  32'(baddr_a),  32'(e_addr));
      chk("m_bus_wdata", 32'(bwdata_a), 32'(e_wdata));
      chk("m_req_rdata", 32'(rdata_a),  32'(e_rdata));
      chk("m_req_ack",   32'(ack_a),    32'(e_ack));
      chk("m_req_err",   32'(err_a),    32'(e_err));
    end
  end

  // Saturated fixed priority: one transaction per 3 cycles, always requester 0.
  int n_b = 0;
  int v_b = 0;
  always @(posedge clk) begin
    if (rst) begin n_b = 0; v_b = 1; end
    else n_b++;
  end
  always @(negedge clk) begin
    if (v_b != 0) begin
      chk("fp_ack", 32'(ack_b), (n_b % 3 == 2) ? 32'h1 : 32'h0);
      chk("fp_err", 32'(err_b), 32'h0);
    end
  end

  task automatic wait_resp(input int done_at, output logic [3:0] a, output logic [3:0] e,
                           output int nb);
    nb = 0; a = '0; e = '0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if ((ack_a | err_a) != 4'b0) begin a = ack_a; e = err_a; break; end
      if (bgo_a) nb++;
      done_a = (done_at != 0 && nb == done_at);
    end
    done_a = 1'b0;
  endtask

  logic [3:0] a, e;
  int         nb;
  int         order [4];
  int         n_ord;

  initial begin
    rst = 1'b1; go_a = '0; rd_a = '0; addr_a = '0; wd_a = '0; done_a = 1'b0; brd_a = '0;
    go_b = 4'hF; rd_b = '0; addr_b = '0; wd_b = '0; done_b = 1'b1; brd_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_bus_go", 32'(bgo_a), 0);
    chk("rst_bus_addr", 32'(baddr_a), 0);
    chk("rst_ack", 32'(ack_a), 0);
    rst = 1'b0;

    // Single write, bus_done on second BUSY cycle
    addr_a[1] = 16'h0040; wd_a[1] = 16'hBEEF; rd_a[1] = 1'b0; go_a = 4'b0010;
    @(negedge clk);
    chk("wr_bus_go", 32'(bgo_a), 1);
    chk("wr_bus_addr", 32'(baddr_a), 32'h0040);
    chk("wr_bus_wdata", 32'(bwdata_a), 32'hBEEF);
    chk("wr_bus_read", 32'(bread_a), 0);
    addr_a[1] = 16'hFFFF; wd_a[1] = 16'h0000;
    @(negedge clk);
    chk("wr_hold_addr", 32'(baddr_a), 32'h0040);
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    chk("wr_ack", 32'(ack_a), 32'b0010);
    chk("wr_go_low", 32'(bgo_a), 0);
    go_a = '0;
    @(negedge clk);
    chk("wr_ack_one_cycle", 32'(ack_a), 0);

    // Reset mid-BUSY (pointer is 2 here); nothing may be reported afterwards
    go_a = 4'b0100; addr_a[2] = 16'h0AA0; wd_a[2] = 16'h1111;
    @(negedge clk);
    chk("mr_busy", 32'(bgo_a), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_bus_go", 32'(bgo_a), 0);
    chk("mr_bus_addr", 32'(baddr_a), 0);
    chk("mr_bus_wdata", 32'(bwdata_a), 0);
    chk("mr_ack_err", 32'(ack_a | err_a), 0);

    // Round-robin fairness from a freshly reset pointer
    for (int i = 0; i < 4; i++) begin
      addr_a[i] = 16'(16'h0100 + i); wd_a[i] = 16'(i * 3); rd_a[i] = 1'b0;
    end
    go_a = 4'hF; done_a = 1'b1; n_ord = 0;
    for (int g = 0; g < 40 && n_ord < 4; g++) begin
      @(negedge clk);
      if (ack_a != 4'b0) begin
        for (int i = 0; i < 4; i++) if (ack_a[i]) order[n_ord] = i;
        n_ord++;
        go_a = go_a & ~ack_a;
      end
    end
    done_a = 1'b0; go_a = '0;
    chk("rr_count", 32'(n_ord), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i));

    // Read from requester 3, then a write must leave rdata alone
    rd_a[3] = 1'b1; addr_a[3] = 16'h0012; brd_a = 16'h1234; go_a = 4'b1000;
    wait_resp(1, a, e, nb);
    chk("rd_ack", 32'(a), 32'b1000);
    chk("rd_rdata", 32'(rdata_a), 32'h1234);
    go_a = '0;
    rd_a[2] = 1'b0; brd_a = 16'h5555; go_a = 4'b0100;
    wait_resp(1, a, e, nb);
    chk("wr2_ack", 32'(a), 32'b0100);
    chk("wr2_rdata_kept", 32'(rdata_a), 32'h1234);
    go_a = '0;

    // Timeout, then bus_done on exactly the last watchdog cycle
    rd_a[0] = 1'b0; go_a = 4'b0001;
    wait_resp(0, a, e, nb);
    chk("to_err", 32'(e), 32'b0001);
    chk("to_no_ack", 32'(a), 0);
    chk("to_busy_cycles", 32'(nb), TO);
    chk("to_go_low", 32'(bgo_a), 0);
    go_a = '0;
    @(negedge clk);
    go_a = 4'b0001;
    wait_resp(TO, a, e, nb);
    chk("tl_ack", 32'(a), 32'b0001);
    chk("tl_no_err", 32'(e), 0);
    go_a = '0;
    @(negedge clk);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (go_a[i] && (ack_a[i] || err_a[i])) go_a[i] = 1'b0;
        else if (go_a[i]) begin
          if ($urandom_range(7) == 0) begin addr_a[i] = 16'($urandom); wd_a[i] = 16'($urandom); end
          if ($urandom_range(31) == 0) go_a[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          go_a[i] = 1'b1; rd_a[i] = 1'($urandom); addr_a[i] = 16'($urandom); wd_a[i] = 16'($urandom);
        end
      end
      done_a = ($urandom_range(2) == 0);
      brd_a  = 16'($urandom);
      rst    = ($urandom_range(499) == 0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
